// File: rtl/cv32e40p_rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: requester
// identifiers, a default-width request record and a modular index helper.
package cv32e40p_rf_wb_arbiter_pkg;

    // Requester slots in the default four-producer core configuration
    typedef enum logic [1:0] {
        WB_REQ_ALU  = 2'd0,
        WB_REQ_LSU  = 2'd1,
        WB_REQ_MULT = 2'd2,
        WB_REQ_FPU  = 2'd3
    } wb_req_id_e;

    localparam int WB_DEFAULT_NUM_REQ    = 4;
    localparam int WB_DEFAULT_ADDR_WIDTH = 6;
    localparam int WB_DEFAULT_DATA_WIDTH = 32;

    // One writeback request at the default core widths
    typedef struct packed {
        logic                             valid;
        logic [WB_DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [WB_DEFAULT_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Advance a requester index by one, wrapping at n
    function automatic int wbWrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cv32e40p_wb_rr_picker.sv
// Rotating-priority find-first: starting at rr_i and walking upward modulo N,
// reports the first set bit of mask_i as a one-hot vector and as an index.
module cv32e40p_wb_rr_picker
    import cv32e40p_rf_wb_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] rr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    // Walk the candidates in rotated order and stop at the first masked-in one
    always_comb begin
        int cand;
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        cand     = int'(rr_i);
        for (int k = 0; k < N; k++) begin
            if (!found_o && mask_i[cand]) begin
                found_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = IW'(cand);
            end
            cand = wbWrapInc(cand, N);
        end
    end

endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Register-file writeback arbiter: shares write ports a and b among NUM_REQ
// result producers with round-robin priority, registers the winning writes,
// and keeps the pending-write scoreboard that ID consults for hazards.
// Optional statistics counters are built when WB_ARB_STATS_EN is defined.
module cv32e40p_rf_wb_arbiter
    import cv32e40p_rf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic                          claim_valid_i,
    input  logic [ADDR_WIDTH-1:0]         claim_addr_i,
    output logic [2**ADDR_WIDTH-1:0]      busy_o,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DATA_WIDTH-1:0]         wdata_a_o,
    output logic                          we_a_o,
    output logic [ADDR_WIDTH-1:0]         waddr_b_o,
    output logic [DATA_WIDTH-1:0]         wdata_b_o,
    output logic                          we_b_o
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_conflict_o,
    output logic [31:0]                   stat_stall_o
`endif
);

    localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] reqAddr [NUM_REQ];
    logic [DATA_WIDTH-1:0] reqData [NUM_REQ];
    logic [NUM_REQ-1:0]    addrNz;
    logic [NUM_REQ-1:0]    validNz;
    logic [NUM_REQ-1:0]    sameAsA;
    logic [NUM_REQ-1:0]    maskB;

    logic [NUM_REQ-1:0]    onehotA;
    logic [NUM_REQ-1:0]    onehotB;
    logic [IW-1:0]         idxA;
    logic [IW-1:0]         idxB;
    logic                  foundA;
    logic                  foundB;
    logic [ADDR_WIDTH-1:0] selAddrA;
    logic [ADDR_WIDTH-1:0] selAddrB;
    logic [DATA_WIDTH-1:0] selDataA;
    logic [DATA_WIDTH-1:0] selDataB;

    logic [IW-1:0]         rr_q;
    logic [IW-1:0]         rr_d;

    logic                  weA_q;
    logic                  weB_q;
    logic [ADDR_WIDTH-1:0] waddrA_q;
    logic [ADDR_WIDTH-1:0] waddrB_q;
    logic [DATA_WIDTH-1:0] wdataA_q;
    logic [DATA_WIDTH-1:0] wdataB_q;

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign reqAddr[gi] = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign reqData[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Classify requesters: a valid request to register 0 never needs a port
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addrNz[i]  = (reqAddr[i] != '0);
            validNz[i] = req_valid_i[i] & addrNz[i];
        end
    end

    cv32e40p_wb_rr_picker #(
        .N (NUM_REQ)
    ) u_pick_a (
        .mask_i   (validNz),
        .rr_i     (rr_q),
        .onehot_o (onehotA),
        .idx_o    (idxA),
        .found_o  (foundA)
    );

    assign selAddrA = reqAddr[idxA];
    assign selDataA = reqData[idxA];

    // Port b candidates exclude the port a winner and anything aimed at the
    // same register, so the two ports never write one address together
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            sameAsA[i] = (reqAddr[i] == selAddrA);
            maskB[i]   = validNz[i] & ~onehotA[i] & ~sameAsA[i];
        end
    end

    cv32e40p_wb_rr_picker #(
        .N (NUM_REQ)
    ) u_pick_b (
        .mask_i   (maskB),
        .rr_i     (rr_q),
        .onehot_o (onehotB),
        .idx_o    (idxB),
        .found_o  (foundB)
    );

    assign selAddrB = reqAddr[idxB];
    assign selDataB = reqData[idxB];

    assign req_ready_o = (req_valid_i & ~addrNz) | onehotA | onehotB;

    // Next round-robin start is just past the last slot handed out this cycle
    always_comb begin
        rr_d = rr_q;
        if (foundB) begin
            rr_d = IW'(wbWrapInc(int'(idxB), NUM_REQ));
        end else if (foundA) begin
            rr_d = IW'(wbWrapInc(int'(idxA), NUM_REQ));
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Output stage: enables follow the grants, address/data hold while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            weA_q    <= 1'b0;
            weB_q    <= 1'b0;
            waddrA_q <= '0;
            waddrB_q <= '0;
            wdataA_q <= '0;
            wdataB_q <= '0;
        end else begin
            weA_q <= foundA;
            weB_q <= foundB;
            if (foundA) begin
                waddrA_q <= selAddrA;
                wdataA_q <= selDataA;
            end
            if (foundB) begin
                waddrB_q <= selAddrB;
                wdataB_q <= selDataB;
            end
        end
    end

    assign we_a_o    = weA_q;
    assign we_b_o    = weB_q;
    assign waddr_a_o = waddrA_q;
    assign waddr_b_o = waddrB_q;
    assign wdata_a_o = wdataA_q;
    assign wdata_b_o = wdataB_q;

    // Scoreboard update: writes clear, flush wipes, claims set last so they win
    always_comb begin
        busy_d = busy_q;
        if (weA_q) begin
            busy_d[waddrA_q] = 1'b0;
        end
        if (weB_q) begin
            busy_d[waddrB_q] = 1'b0;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        if (claim_valid_i && (claim_addr_i != '0)) begin
            busy_d[claim_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

`ifdef WB_ARB_STATS_EN
    logic        conflictSeen;
    logic        stallSeen;
    logic [31:0] statConflict_q;
    logic [31:0] statStall_q;

    assign conflictSeen = |(validNz & ~onehotA & sameAsA);
    assign stallSeen    = |(validNz & ~req_ready_o);

    // Saturating event counters for conflict-skip and stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            statConflict_q <= '0;
            statStall_q    <= '0;
        end else begin
            if (conflictSeen && (statConflict_q != '1)) begin
                statConflict_q <= statConflict_q + 32'd1;
            end
            if (stallSeen && (statStall_q != '1)) begin
                statStall_q <= statStall_q + 32'd1;
            end
        end
    end

    assign stat_conflict_o = statConflict_q;
    assign stat_stall_o    = statStall_q;
`endif

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter. Each step drives requesters,
// checks ready combinationally, queues the write expected one cycle later and
// compares it after the clock edge. Stats ports are used when WB_ARB_STATS_EN
// is defined.
module tb_cv32e40p_rf_wb_arbiter;

    localparam int NR = 4;
    localparam int AW = 6;
    localparam int DW = 32;

    typedef struct {
        logic          weA;
        logic [AW-1:0] addrA;
        logic [DW-1:0] dataA;
        logic          weB;
        logic [AW-1:0] addrB;
        logic [DW-1:0] dataB;
    } expOut_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [NR-1:0]    reqValid;
    logic [NR-1:0]    reqReady;
    logic [NR*AW-1:0] reqAddr;
    logic [NR*DW-1:0] reqData;
    logic             claimValid;
    logic [AW-1:0]    claimAddr;
    logic [2**AW-1:0] busy;
    logic [AW-1:0]    waddrA;
    logic [DW-1:0]    wdataA;
    logic             weA;
    logic [AW-1:0]    waddrB;
    logic [DW-1:0]    wdataB;
    logic             weB;
`ifdef WB_ARB_STATS_EN
    logic [31:0]      statConflict;
    logic [31:0]      statStall;
`endif

    expOut_t expQ[$];
    int checks = 0;
    int errors = 0;

    cv32e40p_rf_wb_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .req_addr_i      (reqAddr),
        .req_data_i      (reqData),
        .claim_valid_i   (claimValid),
        .claim_addr_i    (claimAddr),
        .busy_o          (busy),
        .waddr_a_o       (waddrA),
        .wdata_a_o       (wdataA),
        .we_a_o          (weA),
        .waddr_b_o       (waddrB),
        .wdata_b_o       (wdataB),
        .we_b_o          (weB)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_conflict_o (statConflict),
        .stat_stall_o    (statStall)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drop all requests, claims and flush before a new step
    task automatic clearInputs();
        reqValid   = '0;
        reqAddr    = '0;
        reqData    = '0;
        claimValid = 1'b0;
        claimAddr  = '0;
        flush      = 1'b0;
    endtask

    task automatic setReq(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        reqValid[idx]          = 1'b1;
        reqAddr[idx*AW +: AW]  = addr;
        reqData[idx*DW +: DW]  = data;
    endtask

    task automatic setClaim(input logic [AW-1:0] addr);
        claimValid = 1'b1;
        claimAddr  = addr;
    endtask

    // Compare registered outputs against the oldest scoreboard entry
    task automatic checkOutput();
        expOut_t e;
        if (expQ.size() == 0) begin
            check("queue_underflow", 64'd0, 64'd1);
        end else begin
            e = expQ.pop_front();
            check("we_a", 64'(weA), 64'(e.weA));
            check("we_b", 64'(weB), 64'(e.weB));
            if (e.weA) begin
                check("waddr_a", 64'(waddrA), 64'(e.addrA));
                check("wdata_a", 64'(wdataA), 64'(e.dataA));
            end
            if (e.weB) begin
                check("waddr_b", 64'(waddrB), 64'(e.addrB));
                check("wdata_b", 64'(wdataB), 64'(e.dataB));
            end
        end
    endtask

    // Check ready for the driven inputs, queue the expected writes, clock once
    task automatic applyStimulus(input logic [NR-1:0] expReady,
                                 input logic eWeA, input logic [AW-1:0] eAddrA, input logic [DW-1:0] eDataA,
                                 input logic eWeB, input logic [AW-1:0] eAddrB, input logic [DW-1:0] eDataB);
        expOut_t e;
        #1;
        check("ready", 64'(reqReady), 64'(expReady));
        e.weA = eWeA; e.addrA = eAddrA; e.dataA = eDataA;
        e.weB = eWeB; e.addrB = eAddrB; e.dataB = eDataB;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idleStep();
        applyStimulus(4'b0000, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;
        idleStep();
        check("rst_waddr_a", 64'(waddrA), 64'd0);
        check("rst_wdata_a", 64'(wdataA), 64'd0);
        check("rst_waddr_b", 64'(waddrB), 64'd0);
        check("rst_wdata_b", 64'(wdataB), 64'd0);
        check("rst_busy", busy, 64'd0);
        rst = 1'b0;

        // Single ALU write, rr 0 -> 1
        clearInputs(); setReq(0, 6'd5, 32'hA5A5A5A5);
        applyStimulus(4'b0001, 1'b1, 6'd5, 32'hA5A5A5A5, 1'b0, '0, '0);
        clearInputs(); idleStep();
        check("hold_waddr_a", 64'(waddrA), 64'd5);

        // Lone FPU request moves rr back to 0
        clearInputs(); setReq(3, 6'd8, 32'h33333333);
        applyStimulus(4'b1000, 1'b1, 6'd8, 32'h33333333, 1'b0, '0, '0);

        // All four valid: 0,1 first, then 2,3; rr ends at 0
        clearInputs();
        setReq(0, 6'd1, 32'h11111111); setReq(1, 6'd2, 32'h22222222);
        setReq(2, 6'd3, 32'h30303030); setReq(3, 6'd4, 32'h44444444);
        applyStimulus(4'b0011, 1'b1, 6'd1, 32'h11111111, 1'b1, 6'd2, 32'h22222222);
        clearInputs();
        setReq(2, 6'd3, 32'h30303030); setReq(3, 6'd4, 32'h44444444);
        applyStimulus(4'b1100, 1'b1, 6'd3, 32'h30303030, 1'b1, 6'd4, 32'h44444444);

        // Same-address conflict: req1 skipped, req2 takes port b, rr -> 3
        clearInputs();
        setReq(0, 6'd7, 32'h70); setReq(1, 6'd7, 32'h71); setReq(2, 6'd9, 32'h90);
        applyStimulus(4'b0101, 1'b1, 6'd7, 32'h70, 1'b1, 6'd9, 32'h90);
        clearInputs(); setReq(1, 6'd7, 32'h71);
        applyStimulus(4'b0010, 1'b1, 6'd7, 32'h71, 1'b0, '0, '0);

        // rr=2: addr-0 request is ready without a slot, req0 wins port a, rr -> 1
        clearInputs(); setReq(3, 6'd0, 32'hDEAD); setReq(0, 6'd4, 32'h44);
        applyStimulus(4'b1001, 1'b1, 6'd4, 32'h44, 1'b0, '0, '0);
        // rr=1 so req1 takes port a ahead of req0
        clearInputs(); setReq(0, 6'd10, 32'hA0); setReq(1, 6'd11, 32'hB1);
        applyStimulus(4'b0011, 1'b1, 6'd11, 32'hB1, 1'b1, 6'd10, 32'hA0);

        // Scoreboard: claim 12, write 12, bit clears the cycle after the write
        clearInputs(); setClaim(6'd12); idleStep();
        check("busy_claim12", busy, 64'd1 << 12);
        clearInputs(); setReq(2, 6'd12, 32'hC2);
        applyStimulus(4'b0100, 1'b1, 6'd12, 32'hC2, 1'b0, '0, '0);
        check("busy_during_write", busy, 64'd1 << 12);
        clearInputs(); idleStep();
        check("busy_cleared", busy, 64'd0);

        // Claim in the clearing cycle wins
        clearInputs(); setClaim(6'd12); idleStep();
        clearInputs(); setReq(0, 6'd12, 32'hC0);
        applyStimulus(4'b0001, 1'b1, 6'd12, 32'hC0, 1'b0, '0, '0);
        clearInputs(); setClaim(6'd12); idleStep();
        check("busy_claim_wins", busy, 64'd1 << 12);

        // Flush with simultaneous claim, ignored claim of r0, plain flush
        clearInputs(); flush = 1'b1; setClaim(6'd33); idleStep();
        check("busy_flush_claim", busy, 64'd1 << 33);
        clearInputs(); setClaim(6'd0); idleStep();
        check("busy_r0_const", busy, 64'd1 << 33);
        clearInputs(); flush = 1'b1; idleStep();
        check("busy_flush", busy, 64'd0);

        // Reset while a write is registered and a busy bit is set
        clearInputs(); setClaim(6'd15); idleStep();
        clearInputs(); setReq(0, 6'd15, 32'hF0);
        applyStimulus(4'b0001, 1'b1, 6'd15, 32'hF0, 1'b0, '0, '0);
        check("busy_before_rst", busy, 64'd1 << 15);
        clearInputs(); rst = 1'b1; idleStep();
        check("rst2_waddr_a", 64'(waddrA), 64'd0);
        check("rst2_wdata_a", 64'(wdataA), 64'd0);
        check("rst2_busy", busy, 64'd0);
        rst = 1'b0;
`ifdef WB_ARB_STATS_EN
        check("stat_conflict_rst", 64'(statConflict), 64'd0);
        check("stat_stall_rst", 64'(statStall), 64'd0);
`endif

        // After reset rr is 0 again: req0 before req1 on a shared address
        clearInputs(); setReq(0, 6'd7, 32'h7A); setReq(1, 6'd7, 32'h7B);
        applyStimulus(4'b0001, 1'b1, 6'd7, 32'h7A, 1'b0, '0, '0);
        clearInputs(); setReq(1, 6'd7, 32'h7B);
        applyStimulus(4'b0010, 1'b1, 6'd7, 32'h7B, 1'b0, '0, '0);
`ifdef WB_ARB_STATS_EN
        check("stat_conflict", 64'(statConflict), 64'd1);
        check("stat_stall", 64'(statStall), 64'd1);
`endif

        check("queue_drained", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
